// File: rtl/coin_lane_judge.sv
// coin_lane_judge: judge/controller facing a row of coin sprites.
// Spawns coins on pseudo-random lanes at frame rate. Each lane is tracked
// through TRAVEL -> WINDOW -> COOLDOWN. Button presses are judged as hits or
// misses, and the block keeps score, combo and miss count and raises game over.
//
// Ports:
//   i_clk          pixel clock (only clock)
//   i_rst          synchronous active-high reset
//   i_v_sync       vertical sync level; its rising edge is the frame tick
//   i_enable       allows new spawns; lanes already in flight are still judged
//   i_in_position  per-lane "coin is in the hit zone"
//   i_btn          per-lane debounced button level
//   o_active       per-lane coin active (TRAVEL or WINDOW)
//   o_score        saturating hit count
//   o_combo        consecutive hits, saturating at 255
//   o_misses       miss count, capped at MAX_MISSES
//   o_hit_pulse    one-cycle pulse: at least one hit this cycle
//   o_miss_pulse   one-cycle pulse: at least one miss this cycle
//   o_game_over    sticky until reset
module coin_lane_judge #(
    parameter int NUM_LANES         = 3,
    parameter int SPAWN_INTERVAL    = 30,
    parameter int MAX_TRAVEL_FRAMES = 60,
    parameter int COOLDOWN_FRAMES   = 2,
    parameter int MAX_MISSES        = 8
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_v_sync,
    input  logic                 i_enable,
    input  logic [NUM_LANES-1:0] i_in_position,
    input  logic [NUM_LANES-1:0] i_btn,
    output logic [NUM_LANES-1:0] o_active,
    output logic [15:0]          o_score,
    output logic [7:0]           o_combo,
    output logic [7:0]           o_misses,
    output logic                 o_hit_pulse,
    output logic                 o_miss_pulse,
    output logic                 o_game_over
);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_TRAVEL   = 2'd1,
        ST_WINDOW   = 2'd2,
        ST_COOLDOWN = 2'd3
    } lane_state_t;

    localparam logic [15:0] SPAWN_LAST  = 16'(SPAWN_INTERVAL - 1);
    localparam logic [15:0] TRAVEL_LAST = 16'(MAX_TRAVEL_FRAMES - 1);
    localparam logic [15:0] COOL_LAST   = 16'(COOLDOWN_FRAMES - 1);
    localparam logic [7:0]  MISS_LIMIT  = 8'(MAX_MISSES);
    localparam logic [7:0]  LANE_COUNT  = 8'(NUM_LANES);

    // Galois LFSR step, polynomial x^16+x^14+x^13+x^11 (right-shift form).
    function automatic logic [15:0] lfsr_next(input logic [15:0] cur);
        return {1'b0, cur[15:1]} ^ (cur[0] ? 16'hB400 : 16'h0000);
    endfunction

    // Number of set bits in a per-lane vector.
    function automatic logic [7:0] count_ones(input logic [NUM_LANES-1:0] v);
        logic [7:0] n;
        n = 8'd0;
        for (int i = 0; i < NUM_LANES; i++) begin
            n = n + {7'd0, v[i]};
        end
        return n;
    endfunction

    logic                 vs_q_r;
    logic [NUM_LANES-1:0] btn_q_r;
    logic [15:0]          lfsr_r;
    logic [15:0]          spawn_cnt_r;
    lane_state_t          state_r [NUM_LANES];
    logic [15:0]          timer_r [NUM_LANES];
    logic [NUM_LANES-1:0] active_r;
    logic [15:0]          score_r;
    logic [7:0]           combo_r;
    logic [7:0]           misses_r;
    logic                 hit_pulse_r;
    logic                 miss_pulse_r;
    logic                 game_over_r;

    logic                 tick_s;
    logic [NUM_LANES-1:0] press_s;
    logic                 spawn_wrap_s;
    logic                 spawn_s;
    logic [7:0]           spawn_lane_s;
    lane_state_t          state_s [NUM_LANES];
    logic [15:0]          timer_s [NUM_LANES];
    logic [NUM_LANES-1:0] hit_s;
    logic [NUM_LANES-1:0] miss_s;
    logic [7:0]           nh_s;
    logic [7:0]           nm_s;
    logic [16:0]          score_sum_s;
    logic [8:0]           combo_sum_s;
    logic [8:0]           misses_sum_s;
    logic [15:0]          score_next_s;
    logic [7:0]           combo_next_s;
    logic [7:0]           misses_next_s;

    // Frame tick, button edges and spawn decision (uses the pre-advance LFSR).
    always_comb begin
        tick_s       = i_v_sync & ~vs_q_r;
        press_s      = i_btn & ~btn_q_r;
        spawn_wrap_s = tick_s & (spawn_cnt_r == SPAWN_LAST);
        spawn_s      = spawn_wrap_s & i_enable & ~game_over_r;
        spawn_lane_s = lfsr_r[7:0] % LANE_COUNT;
    end

    // Per-lane next state; game over retires in-flight coins without judging them.
    always_comb begin
        for (int l = 0; l < NUM_LANES; l++) begin
            state_s[l] = state_r[l];
            timer_s[l] = timer_r[l];
            hit_s[l]   = 1'b0;
            miss_s[l]  = 1'b0;
            case (state_r[l])
                ST_IDLE: begin
                    if (spawn_s && (spawn_lane_s == 8'(l))) begin
                        state_s[l] = ST_TRAVEL;
                        timer_s[l] = 16'd0;
                    end else begin
                        state_s[l] = ST_IDLE;
                    end
                end
                ST_TRAVEL: begin
                    if (game_over_r) begin
                        state_s[l] = ST_COOLDOWN;
                        timer_s[l] = 16'd0;
                    end else if (tick_s && (timer_r[l] == TRAVEL_LAST)) begin
                        state_s[l] = ST_COOLDOWN;
                        timer_s[l] = 16'd0;
                        miss_s[l]  = 1'b1;
                    end else if (i_in_position[l]) begin
                        state_s[l] = ST_WINDOW;
                        timer_s[l] = timer_r[l] + {15'd0, tick_s};
                    end else begin
                        timer_s[l] = timer_r[l] + {15'd0, tick_s};
                    end
                end
                ST_WINDOW: begin
                    // A press wins over the coin leaving the zone on the same cycle.
                    if (game_over_r) begin
                        state_s[l] = ST_COOLDOWN;
                        timer_s[l] = 16'd0;
                    end else if (press_s[l]) begin
                        state_s[l] = ST_COOLDOWN;
                        timer_s[l] = 16'd0;
                        hit_s[l]   = 1'b1;
                    end else if (!i_in_position[l] || (tick_s && (timer_r[l] == TRAVEL_LAST))) begin
                        state_s[l] = ST_COOLDOWN;
                        timer_s[l] = 16'd0;
                        miss_s[l]  = 1'b1;
                    end else begin
                        timer_s[l] = timer_r[l] + {15'd0, tick_s};
                    end
                end
                ST_COOLDOWN: begin
                    if (tick_s && (timer_r[l] == COOL_LAST)) begin
                        state_s[l] = ST_IDLE;
                        timer_s[l] = 16'd0;
                    end else begin
                        timer_s[l] = timer_r[l] + {15'd0, tick_s};
                    end
                end
                default: begin
                    state_s[l] = ST_IDLE;
                    timer_s[l] = 16'd0;
                end
            endcase
        end
    end

    // Saturating score/combo/miss arithmetic for this cycle's hits and misses.
    always_comb begin
        nh_s          = count_ones(hit_s);
        nm_s          = count_ones(miss_s);
        score_sum_s   = {1'b0, score_r} + {9'd0, nh_s};
        combo_sum_s   = {1'b0, combo_r} + {1'b0, nh_s};
        misses_sum_s  = {1'b0, misses_r} + {1'b0, nm_s};
        score_next_s  = score_sum_s[16] ? 16'hFFFF : score_sum_s[15:0];
        if (nm_s != 8'd0) begin
            combo_next_s = 8'd0;
        end else begin
            combo_next_s = combo_sum_s[8] ? 8'hFF : combo_sum_s[7:0];
        end
        if (misses_sum_s >= {1'b0, MISS_LIMIT}) begin
            misses_next_s = MISS_LIMIT;
        end else begin
            misses_next_s = misses_sum_s[7:0];
        end
    end

    // State, counters and registered outputs.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            vs_q_r       <= 1'b0;
            btn_q_r      <= '0;
            lfsr_r       <= 16'hACE1;
            spawn_cnt_r  <= 16'd0;
            for (int l = 0; l < NUM_LANES; l++) begin
                state_r[l] <= ST_IDLE;
                timer_r[l] <= 16'd0;
            end
            active_r     <= '0;
            score_r      <= 16'd0;
            combo_r      <= 8'd0;
            misses_r     <= 8'd0;
            hit_pulse_r  <= 1'b0;
            miss_pulse_r <= 1'b0;
            game_over_r  <= 1'b0;
        end else begin
            vs_q_r  <= i_v_sync;
            btn_q_r <= i_btn;
            if (tick_s) begin
                lfsr_r      <= lfsr_next(lfsr_r);
                spawn_cnt_r <= spawn_wrap_s ? 16'd0 : spawn_cnt_r + 16'd1;
            end
            for (int l = 0; l < NUM_LANES; l++) begin
                state_r[l]  <= state_s[l];
                timer_r[l]  <= timer_s[l];
                active_r[l] <= (state_s[l] == ST_TRAVEL) || (state_s[l] == ST_WINDOW);
            end
            hit_pulse_r  <= (nh_s != 8'd0);
            miss_pulse_r <= (nm_s != 8'd0);
            if (!game_over_r) begin
                score_r  <= score_next_s;
                combo_r  <= combo_next_s;
                misses_r <= misses_next_s;
                if (misses_next_s == MISS_LIMIT) begin
                    game_over_r <= 1'b1;
                end
            end
        end
    end

    assign o_active     = active_r;
    assign o_score      = score_r;
    assign o_combo      = combo_r;
    assign o_misses     = misses_r;
    assign o_hit_pulse  = hit_pulse_r;
    assign o_miss_pulse = miss_pulse_r;
    assign o_game_over  = game_over_r;

endmodule

// File: tb/tb_coin_lane_judge.sv
// Randomized scoreboard bench for coin_lane_judge. A behavioural game model
// predicts each edge; predictions are queued and a monitor compares them
// against the DUT after every clock edge.
module tb_coin_lane_judge;

    localparam int NL = 3;
    localparam int SI = 30;
    localparam int MT = 60;
    localparam int CF = 2;
    localparam int MM = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          vs = 1'b0;
    logic          en = 1'b0;
    logic [NL-1:0] inpos = '0;
    logic [NL-1:0] btn = '0;
    logic [NL-1:0] act;
    logic [15:0]   score;
    logic [7:0]    combo;
    logic [7:0]    misses;
    logic          hp;
    logic          mp;
    logic          go;

    always #5 clk = ~clk;

    coin_lane_judge #(
        .NUM_LANES(NL), .SPAWN_INTERVAL(SI), .MAX_TRAVEL_FRAMES(MT),
        .COOLDOWN_FRAMES(CF), .MAX_MISSES(MM)
    ) dut (
        .i_clk(clk), .i_rst(rst), .i_v_sync(vs), .i_enable(en),
        .i_in_position(inpos), .i_btn(btn), .o_active(act),
        .o_score(score), .o_combo(combo), .o_misses(misses),
        .o_hit_pulse(hp), .o_miss_pulse(mp), .o_game_over(go)
    );

    typedef struct {
        int            edge_n;
        logic [NL-1:0] active;
        int            score;
        int            combo;
        int            misses;
        bit            go;
    } cyc_exp_t;

    typedef struct {
        int edge_n;
        bit hit;
        bit miss;
    } evt_t;

    cyc_exp_t cyc_q[$];
    evt_t     evt_q[$];
    int       n_checks = 0;
    int       n_fail = 0;
    int       edge_no = 0;
    int       n_hit_events = 0;
    int       n_miss_events = 0;

    always @(posedge clk) edge_no <= edge_no + 1;

    // Game model state: a coin's life is tracked as "flying" plus its age in frames.
    bit        m_vs;
    bit [NL-1:0] m_btn;
    bit [15:0] m_lfsr;
    int        m_cnt;
    bit        m_fly   [NL];
    bit        m_zoned [NL];
    int        m_age   [NL];
    int        m_cool  [NL];
    int        m_score, m_combo, m_miss;
    bit        m_go;
    // Per-coin behaviour plan chosen at spawn: zone start/length in frames, will press.
    int        p_zs    [NL];
    int        p_zl    [NL];
    bit        p_press [NL];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at edge %0d: got %0h expected %0h", name, edge_no, got, exp);
        end
    endtask

    function automatic bit [15:0] lfsr_adv(input bit [15:0] v);
        bit [15:0] r;
        r = v >> 1;
        if (v[0]) r = r ^ 16'hB400;
        return r;
    endfunction

    task automatic model_reset();
        m_vs = 1'b0; m_btn = '0; m_lfsr = 16'hACE1; m_cnt = 0;
        for (int l = 0; l < NL; l++) begin
            m_fly[l] = 1'b0; m_zoned[l] = 1'b0; m_age[l] = 0; m_cool[l] = 0;
            p_zs[l] = 100; p_zl[l] = 1; p_press[l] = 1'b0;
        end
        m_score = 0; m_combo = 0; m_miss = 0; m_go = 1'b0;
    endtask

    // Predict the effect of the next clock edge given the inputs now applied.
    task automatic model_step();
        bit tick;
        bit [NL-1:0] press;
        int sp_lane, nh, nm;
        bit hit, miss;
        cyc_exp_t ce;
        evt_t ev;
        nh = 0; nm = 0;
        if (rst) begin
            model_reset();
        end else begin
            tick = vs && !m_vs;
            press = btn & ~m_btn;
            m_vs = vs; m_btn = btn;
            sp_lane = -1;
            if (tick) begin
                if (m_cnt == SI - 1) begin
                    m_cnt = 0;
                    if (en && !m_go) sp_lane = int'(m_lfsr[7:0]) % NL;
                end else begin
                    m_cnt++;
                end
                m_lfsr = lfsr_adv(m_lfsr);
            end
            for (int l = 0; l < NL; l++) begin
                if (m_fly[l]) begin
                    hit = 1'b0; miss = 1'b0;
                    if (m_go) begin
                        hit = 1'b0;
                    end else if (!m_zoned[l]) begin
                        if (tick && m_age[l] + 1 == MT) miss = 1'b1;
                        else if (inpos[l]) m_zoned[l] = 1'b1;
                    end else begin
                        if (press[l]) hit = 1'b1;
                        else if (!inpos[l]) miss = 1'b1;
                        else if (tick && m_age[l] + 1 == MT) miss = 1'b1;
                    end
                    if (m_go || hit || miss) begin
                        m_fly[l] = 1'b0; m_cool[l] = CF;
                    end else begin
                        m_age[l] += int'(tick);
                    end
                    nh += int'(hit); nm += int'(miss);
                end else if (m_cool[l] > 0) begin
                    if (tick) m_cool[l]--;
                end else if (sp_lane == l) begin
                    m_fly[l] = 1'b1; m_zoned[l] = 1'b0; m_age[l] = 0;
                    p_zs[l] = int'($urandom_range(2, 70));
                    p_zl[l] = int'($urandom_range(1, 5));
                    p_press[l] = ($urandom_range(0, 3) != 0);
                end
            end
            if (!m_go) begin
                m_score = (m_score + nh > 65535) ? 65535 : m_score + nh;
                m_combo = (nm != 0) ? 0 : ((m_combo + nh > 255) ? 255 : m_combo + nh);
                m_miss = (m_miss + nm > MM) ? MM : m_miss + nm;
                if (m_miss == MM) m_go = 1'b1;
            end
        end
        ce.edge_n = edge_no + 1;
        for (int l = 0; l < NL; l++) ce.active[l] = m_fly[l];
        ce.score = m_score; ce.combo = m_combo; ce.misses = m_miss; ce.go = m_go;
        cyc_q.push_back(ce);
        if (nh != 0 || nm != 0) begin
            ev.edge_n = edge_no + 1; ev.hit = (nh != 0); ev.miss = (nm != 0);
            evt_q.push_back(ev);
        end
    endtask

    // Apply one cycle of stimulus, predict, then wait for the next falling edge.
    task automatic step(input bit do_rst, input bit en_v, input bit nopress);
        rst = do_rst;
        en = en_v;
        vs = ($urandom_range(0, 2) == 0);
        for (int l = 0; l < NL; l++) begin
            inpos[l] = m_fly[l] && (m_age[l] >= p_zs[l]) && (m_age[l] < p_zs[l] + p_zl[l]);
            if (m_fly[l]) btn[l] = (p_press[l] && !nopress) ? 1'($urandom_range(0, 1)) : 1'b0;
            else btn[l] = 1'($urandom_range(0, 1));
        end
        model_step();
        @(negedge clk);
    endtask

    // Monitor: compare every edge's state and match pulses against predicted events.
    initial begin
        cyc_exp_t ce;
        evt_t ev;
        forever begin
            @(posedge clk);
            #1;
            if (cyc_q.size() == 0) begin
                n_checks++; n_fail++;
                $display("FAIL no_prediction at edge %0d: got empty queue expected an entry", edge_no);
            end else begin
                ce = cyc_q.pop_front();
                check("edge_align", 32'(edge_no), 32'(ce.edge_n));
                check("active", 32'(act), 32'(ce.active));
                check("score", 32'(score), 32'(ce.score));
                check("combo", 32'(combo), 32'(ce.combo));
                check("misses", 32'(misses), 32'(ce.misses));
                check("game_over", 32'(go), 32'(ce.go));
            end
            while (evt_q.size() > 0 && evt_q[0].edge_n < edge_no) begin
                ev = evt_q.pop_front();
                n_checks++; n_fail++;
                $display("FAIL stale_event: got no pulse at edge %0d expected one", ev.edge_n);
            end
            if (hp === 1'b1 || mp === 1'b1) begin
                if (evt_q.size() == 0 || evt_q[0].edge_n != edge_no) begin
                    n_checks++; n_fail++;
                    $display("FAIL unexpected_pulse at edge %0d: got hit=%0b miss=%0b expected none", edge_no, hp, mp);
                end else begin
                    ev = evt_q.pop_front();
                    check("hit_pulse", 32'(hp), 32'(ev.hit));
                    check("miss_pulse", 32'(mp), 32'(ev.miss));
                    n_hit_events += int'(ev.hit);
                    n_miss_events += int'(ev.miss);
                end
            end else begin
                check("pulses_idle", {30'd0, hp, mp}, 32'd0);
                if (evt_q.size() > 0 && evt_q[0].edge_n == edge_no) begin
                    ev = evt_q.pop_front();
                    n_checks++; n_fail++;
                    $display("FAIL missing_pulse at edge %0d: got none expected hit=%0b miss=%0b", edge_no, ev.hit, ev.miss);
                end
            end
        end
    end

    // Stimulus: random play, enable gap, forced-miss game over, mid-flight reset.
    initial begin
        bit found;
        model_reset();
        for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b0);
        check("reset_active", 32'(act), 32'd0);
        check("reset_score", 32'(score), 32'd0);
        for (int i = 0; i < 1800; i++) step(1'b0, !(i >= 700 && i < 1000), 1'b0);
        check("saw_hits", 32'(n_hit_events > 0), 32'd1);

        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 3200; i++) step(1'b0, 1'b1, 1'b1);
        check("game_over_set", 32'(go), 32'd1);
        check("game_over_misses", 32'(misses), 32'(MM));
        check("game_over_idle", 32'(act), 32'd0);

        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0);
        found = 1'b0;
        for (int i = 0; i < 800 && !found; i++) begin
            step(1'b0, 1'b1, 1'b0);
            for (int l = 0; l < NL; l++) if (m_fly[l] && !m_zoned[l]) found = 1'b1;
        end
        if (!found) begin
            n_checks++; n_fail++;
            $display("FAIL travel_timeout: got no lane in travel expected one within 800 cycles");
        end
        check("travel_before_reset", 32'(act != '0), 32'd1);
        step(1'b1, 1'b1, 1'b0);
        check("rst_active", 32'(act), 32'd0);
        check("rst_score", 32'(score), 32'd0);
        check("rst_misses", 32'(misses), 32'd0);
        check("rst_game_over", 32'(go), 32'd0);
        for (int i = 0; i < 20; i++) step(1'b0, 1'b1, 1'b0);

        check("queue_drained", 32'(cyc_q.size() + evt_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
